// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-bit serial link.
// Used by the serializer, its hold buffer and the bench.
package serial_link_pkg;

  localparam int LINK_WIDTH = 4;
  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } p2s_state_t;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Parallel word handshake into the serializer.
// Source drives data_in/data_valid, sink drives data_ready.
interface parallel_to_serial_if #(
  parameter int WIDTH = serial_link_pkg::LINK_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/word_hold_buffer.sv
// Single-entry holding register in front of the shifter.
// Ready is simply the inverse of the occupied flag.
module word_hold_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] hold,
  output logic             hold_valid,
  output logic             data_ready
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= din;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign data_ready = !hold_valid;

endmodule

// File: rtl/parallel_to_serial.sv
// MSB-first word serializer with a one-word holding buffer.
// Line outputs are registered one cycle behind the FSM state.
module parallel_to_serial
  import serial_link_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH,
  parameter int GAP   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  parallel_to_serial_if.slave  link,
  output logic                 serial_out,
  output logic                 frame_start,
  output logic                 last_bit,
  output logic                 busy
);

  localparam int BW = cnt_bits(WIDTH);
  localparam int GW = cnt_bits(GAP + 1);
  localparam int GL = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GL);

  p2s_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             ready;
  logic             hs;
  logic             push;
  logic             pop;
  logic             load_in;

  assign link.data_ready = ready;
  assign hs = link.data_valid && ready;

  word_hold_buffer #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .din        (link.data_in),
    .hold       (hold),
    .hold_valid (hold_valid),
    .data_ready (ready)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load_in = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) load_in = 1'b1;
      end
      ST_SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else if (hold_valid) begin
            pop = 1'b1;
          end else if (hs) begin
            load_in = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          if (hold_valid)  pop     = 1'b1;
          else if (hs)     load_in = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // next-word loads override the shift path
    if (pop) begin
      shift_d = hold;
      bit_d   = '0;
      state_d = ST_SHIFT;
    end
    if (load_in) begin
      shift_d = link.data_in;
      bit_d   = '0;
      state_d = ST_SHIFT;
    end
  end

  assign push = hs && !load_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      serial_out  <= 1'b0;
      frame_start <= 1'b0;
      last_bit    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      serial_out  <= (state_q == ST_SHIFT)
                     && shift_q[WIDTH-1];
      frame_start <= (state_q == ST_SHIFT)
                     && (bit_q == '0);
      last_bit    <= (state_q == ST_SHIFT)
                     && (bit_q == BIT_LAST);
    end
  end

  assign busy = (state_q != ST_IDLE) || hold_valid;

endmodule
